tdm_demux4: RTL
===============

# tdm_demux4

Four-slot time-division demultiplexer: the receive-side counterpart of the 4:1 mux. A serial stream of WIDTH-bit samples arrives one slot per enable strobe, with `sync` marking slot 0. The block hunts for frame alignment, steers each slot into a shadow register, and presents a complete frame on channels a..d with a one-cycle `frame_valid` pulse. It sits at the far end of a TDM link whose transmit side is driven by the mux's rotating select.

## Interface
- WIDTH, 1: bit width of each slot sample and each channel output.

- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  serial slot data; sampled only when en=1.
- en  input  1  sample strobe; one slot is consumed per clock with en=1.
- sync  input  1  frame marker; qualified by en; high on the slot-0 sample.
- a  output  WIDTH  channel 0 (slot {s1,s0}=00), registered.
- b  output  WIDTH  channel 1 (slot 01), registered.
- c  output  WIDTH  channel 2 (slot 10), registered.
- d  output  WIDTH  channel 3 (slot 11), registered.
- s1, s0  output  1 each  slot index the next en-beat will be written to.
- locked  output  1  high in LOCKED state.
- frame_valid  output  1  one-cycle pulse: a..d just updated with a new frame.
- sync_err  output  1  one-cycle pulse: framing violation detected.

## Operation
- Reset: the asynchronous rst_n=0 forces a=b=c=d=0, {s1,s0}=00, locked=0, frame_valid=0, sync_err=0, state HUNT, and clears the shadow registers. This applies mid-frame as well; any partial frame is lost.
- The state machine has two states: HUNT and LOCKED.
- HUNT:
  - Beats with en=1, sync=0 are discarded; the slot stays 00.
  - A beat with en=1, sync=1 writes din to shadow[0], sets slot to 01, and moves to LOCKED.
- LOCKED, on each beat with en=1:
  - slot 00, sync=1: normal frame start. Write shadow[0] and set slot to 01.
  - slot 00, sync=0: lost alignment. Pulse sync_err, discard the beat, go to HUNT with slot 00.
  - slot 01 or 10, sync=0: write shadow[slot] and increment slot.
  - slot 11, sync=0: a<=shadow[0], b<=shadow[1], c<=shadow[2], d<=din (the current beat, not the shadow). Pulse frame_valid and wrap the slot to 00.
  - slot 01, 10 or 11 with sync=1: early sync. Pulse sync_err and drop the partial frame; a..d are not updated. Treat the beat as a new slot 0: write shadow[0], set slot to 01, stay LOCKED.
- en=0: no state, slot or shadow change; frame_valid and sync_err are 0.
- a..d change only on frame completion and otherwise hold the last complete frame.
- Slot arithmetic is 2-bit modulo 4. The shadow registers are WIDTH bits; no data transformation is applied.

## Timing
- All outputs are registered; no combinational path exists from inputs to outputs.
- Latency: the slot-11 beat is sampled at edge N. At edge N, a..d update and frame_valid goes high; frame_valid falls at edge N+1.
- The minimum frame period is 4 consecutive en cycles, so frame_valid is never high in two consecutive cycles.
- sync_err is high for exactly one cycle after the offending edge. frame_valid and sync_err are never high together.
- {s1,s0} and locked update on the same edge as the beat that changes them.
- en may be held high continuously (full rate) or gapped arbitrarily; gaps do not affect framing.

## Test plan
- Reset, then 4 full-rate beats with WIDTH=1: din=1,0,1,1 and sync on the first beat. Required: a=1, b=0, c=1, d=1; frame_valid is a single pulse on the 4th edge; locked=1.
- Lock, then 3 back-to-back frames with WIDTH=4: 1,2,3,4 / 5,6,7,8 / 9,A,B,C. Required: three frame_valid pulses 4 cycles apart; final a..d = 9,A,B,C; sync_err stays 0.
- Gapped en (en=0 for 2 cycles between each beat), frame 3,1,0,2. Required: outputs unchanged during the gaps; a..d = 3,1,0,2 after the 4th en beat.
- Lock, frame 1,2,3,4 complete, then sync=1 on the 3rd beat of the next frame. Required: sync_err pulse; a..d remain 1,2,3,4; {s1,s0}=01; locked=1.
- Lock, complete a frame, next slot-0 beat with sync=0. Required: sync_err pulse; locked=0; subsequent beats ignored until a sync beat arrives.
- Assert rst_n=0 asynchronously (between edges) after 2 beats of a frame. Required: immediately a..d=0, {s1,s0}=00, locked=0; after release, a fresh sync frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Bundle of the TDM receive stream and the demultiplexed frame outputs.
// master drives the serial stream; slave is the demultiplexer.
interface tdm_demux4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             en;
    logic             sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             s1;
    logic             s0;
    logic             locked;
    logic             frame_valid;
    logic             sync_err;

    modport master (
        output din, en, sync,
        input  a, b, c, d, s1, s0, locked, frame_valid, sync_err
    );

    modport slave (
        input  din, en, sync,
        output a, b, c, d, s1, s0, locked, frame_valid, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: hunts for the sync-marked slot 0, collects
// four slot samples per frame and publishes them on a..d with frame_valid.
//
// state  | meaning
// HUNT   | no frame alignment; discard beats until an en beat with sync=1
// LOCKED | aligned; slot_q is the slot the next en beat is written to
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q;
    logic [1:0]       slot_q;
    logic [WIDTH-1:0] shadow0_q;
    logic [WIDTH-1:0] shadow1_q;
    logic [WIDTH-1:0] shadow2_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic             frame_valid_q;
    logic             sync_err_q;

    // Slot 3 needs no shadow: the final beat goes straight to d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (bus.en) begin
                case (state_q)
                    HUNT: begin
                        if (bus.sync) begin
                            shadow0_q <= bus.din;
                            slot_q    <= 2'd1;
                            state_q   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (slot_q == 2'd0) begin
                            if (bus.sync) begin
                                shadow0_q <= bus.din;
                                slot_q    <= 2'd1;
                            end else begin
                                sync_err_q <= 1'b1;
                                slot_q     <= 2'd0;
                                state_q    <= HUNT;
                            end
                        end else if (bus.sync) begin
                            // Early sync restarts the frame on this beat.
                            sync_err_q <= 1'b1;
                            shadow0_q  <= bus.din;
                            slot_q     <= 2'd1;
                        end else if (slot_q == 2'd3) begin
                            a_q           <= shadow0_q;
                            b_q           <= shadow1_q;
                            c_q           <= shadow2_q;
                            d_q           <= bus.din;
                            frame_valid_q <= 1'b1;
                            slot_q        <= 2'd0;
                        end else begin
                            if (slot_q == 2'd1) begin
                                shadow1_q <= bus.din;
                            end else begin
                                shadow2_q <= bus.din;
                            end
                            slot_q <= slot_q + 2'd1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        slot_q  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.c           = c_q;
    assign bus.d           = d_q;
    assign bus.s1          = slot_q[1];
    assign bus.s0          = slot_q[0];
    assign bus.locked      = (state_q == LOCKED);
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
endmodule
